// File: rtl/image_op_scheduler.sv
// image_op_scheduler: round-robin arbiter that grants full-frame passes to requesters,
// launches the image datapath with the winner's configuration and supervises the pass.
module image_op_scheduler #(
  parameter  int NREQ    = 4,
  parameter  int WIDTH   = 768,
  parameter  int HEIGHT  = 512,
  parameter  int TIMEOUT = 262143,
  localparam int PAIRS   = WIDTH * HEIGHT / 2,
  localparam int IDW     = $clog2(NREQ),
  localparam int CW      = $clog2(PAIRS + 1),
  localparam int TW      = $clog2(TIMEOUT + 1)
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic [NREQ-1:0]   req,
  input  logic [2*NREQ-1:0] req_op,
  input  logic [8*NREQ-1:0] req_arg,
  input  logic [NREQ-1:0]   req_sign,
  output logic [NREQ-1:0]   ack,
  output logic [NREQ-1:0]   done,
  output logic              err,
  output logic              busy,
  output logic [IDW-1:0]    cur_id,
  output logic              dp_start,
  output logic [1:0]        dp_op,
  output logic [7:0]        dp_arg,
  output logic              dp_sign,
  input  logic              dp_hsync,
  input  logic              dp_done
);
  typedef enum logic [1:0] {IDLE, START, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [IDW-1:0] last_q, last_d, cur_q, cur_d, win;
  logic [1:0] op_q, op_d;
  logic [7:0] arg_q, arg_d;
  logic sign_q, sign_d, err_q, err_d, busy_q, busy_d, start_q, start_d, found;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW:0] sum;
  logic [TW-1:0] wd_q, wd_d;
  logic [NREQ-1:0] ack_q, ack_d, done_q, done_d;
  int idx;
  // Search upward from the requester after the last grant so nobody starves
  always_comb begin
    win = '0;
    found = 1'b0;
    idx = 0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = (int'(last_q) + i) % NREQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win = IDW'(idx);
      end
    end
  end
  // The pair arriving together with dp_done still belongs to the frame
  assign sum = {1'b0, cnt_q} + (CW+1)'(dp_hsync);
  always_comb begin
    state_d = state_q;
    last_d = last_q;
    cur_d = cur_q;
    op_d = op_q;
    arg_d = arg_q;
    sign_d = sign_q;
    cnt_d = cnt_q;
    wd_d = wd_q;
    ack_d = '0;
    done_d = '0;
    err_d = 1'b0;
    start_d = 1'b0;
    case (state_q)
      IDLE: if (found) begin
        state_d = START;
        cur_d = win;
        op_d = req_op[2*win +: 2];
        arg_d = req_arg[8*win +: 8];
        sign_d = req_sign[win];
        ack_d = NREQ'(1) << win;
        start_d = 1'b1;
      end
      START: begin
        state_d = RUN;
        cnt_d = '0;
        wd_d = '0;
        last_d = cur_q;
      end
      RUN: begin
        cnt_d = (dp_hsync && cnt_q != CW'(PAIRS)) ? cnt_q + 1'b1 : cnt_q;
        wd_d = wd_q + 1'b1;
        if (dp_done || wd_q == TW'(TIMEOUT - 1)) begin
          state_d = DONE;
          done_d = NREQ'(1) << cur_q;
          err_d = dp_done ? (sum != (CW+1)'(PAIRS)) : 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= IDLE;
      last_q <= IDW'(NREQ - 1);
      cur_q <= '0;
      op_q <= '0;
      arg_q <= '0;
      sign_q <= 1'b0;
      cnt_q <= '0;
      wd_q <= '0;
      ack_q <= '0;
      done_q <= '0;
      err_q <= 1'b0;
      busy_q <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      cur_q <= cur_d;
      op_q <= op_d;
      arg_q <= arg_d;
      sign_q <= sign_d;
      cnt_q <= cnt_d;
      wd_q <= wd_d;
      ack_q <= ack_d;
      done_q <= done_d;
      err_q <= err_d;
      busy_q <= busy_d;
      start_q <= start_d;
    end
  end
  assign ack = ack_q;
  assign done = done_q;
  assign err = err_q;
  assign busy = busy_q;
  assign cur_id = cur_q;
  assign dp_start = start_q;
  assign dp_op = op_q;
  assign dp_arg = arg_q;
  assign dp_sign = sign_q;
endmodule
